// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout and retire counter
module multicycle_control #(
  parameter int OPWIDTH   = 3,
  parameter int MCODEBITS = 3,
  parameter int TIMEOUT   = 15,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 Branch,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNTW-1:0]      retired
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [OPWIDTH-1:0] ALU_PASS = OPWIDTH'(7);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE
  } state_t;

  state_t               state, state_n;
  logic [MCODEBITS-1:0] op_q;
  logic [WW-1:0]        wait_cnt;
  logic [2:0]           op3;
  logic                 illegal, is_load, is_store, is_set;
  logic                 retire, abort;
  logic [OPWIDTH-1:0]   alu_sel;

  // Opcodes wider than three bits are only legal when the upper bits are clear.
  if (MCODEBITS > 3) begin : g_wide
    assign illegal = |op_q[MCODEBITS-1:3];
  end else begin : g_narrow
    assign illegal = 1'b0;
  end

  assign op3      = op_q[2:0];
  assign is_load  = !illegal && (op3 == 3'b011);
  assign is_store = !illegal && (op3 == 3'b100);
  assign is_set   = !illegal && (op3 == 3'b111);

  always_comb begin
    alu_sel = ALU_PASS;
    if (!illegal) begin
      case (op3)
        3'b000:  alu_sel = OPWIDTH'(0);
        3'b001:  alu_sel = OPWIDTH'(1);
        3'b010:  alu_sel = OPWIDTH'(2);
        default: alu_sel = ALU_PASS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) op_q <= instr;
      if (state == MEM && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                            wait_cnt <= '0;
      if (retire && !(&retired)) retired <= retired + 1'b1;
      if (abort) err <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    Branch   = 1'b0;
    ALUSrc   = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = ALU_PASS;
    retire   = 1'b0;
    abort    = 1'b0;
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    case (state)
      IDLE, DONE: if (start) state_n = FETCH;
      FETCH: begin
        ir_load = 1'b1;
        state_n = DECODE;
      end
      DECODE: state_n = EXEC;
      EXEC: begin
        ALUOp = alu_sel;
        if (illegal) abort = 1'b1;
        else begin
          case (op3)
            3'b011, 3'b100: begin
              ALUSrc  = 1'b1;
              state_n = MEM;
            end
            3'b110: begin
              Branch = !zero;
              retire = 1'b1;
            end
            3'b111: begin
              ALUSrc  = 1'b1;
              state_n = WB;
            end
            default: state_n = WB;
          endcase
        end
      end
      MEM: begin
        ALUOp    = alu_sel;
        ALUSrc   = 1'b1;
        MemWrite = is_store;
        // Completion wins over timeout when both land on the same cycle.
        if (mem_ready) begin
          if (is_store) retire = 1'b1;
          else          state_n = WB;
        end else if (wait_cnt == WAIT_LAST) begin
          abort = 1'b1;
        end
      end
      WB: begin
        ALUOp    = alu_sel;
        ALUSrc   = is_set;
        RegWrite = 1'b1;
        MemtoReg = is_load;
        retire   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (retire || abort) begin
      pc_en   = 1'b1;
      state_n = halt ? DONE : FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset, start, halt, zero, mem_ready;
  logic [3:0] instr;
  logic       ir_load, pc_en, Branch, ALUSrc, MemWrite, MemtoReg, RegWrite;
  logic [3:0] ALUOp;
  logic       busy, done, err;
  logic [1:0] retired;

  multicycle_control #(
    .OPWIDTH(4), .MCODEBITS(4), .TIMEOUT(TIMEOUT), .CNTW(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .instr(instr),
    .zero(zero), .mem_ready(mem_ready), .ir_load(ir_load), .pc_en(pc_en),
    .Branch(Branch), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .busy(busy), .done(done), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int aluop;
    bit branch, rw, m2r, mw, alusrc;
    int retired;
    bit err;
    bit halt;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_retired = 0;
  bit   m_err = 1'b0;
  bit   need_start = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: instruction completions are marked by pc_en; latency is counted from ir_load.
  int   cyc = -1;
  bit   post_pending = 1'b0;
  rec_t post_rec, mon_r;

  always @(negedge clk) begin
    if (reset) begin
      cyc = -1;
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("retired_after", retired, post_rec.retired);
        check("err_after", err, post_rec.err);
        if (post_rec.halt) begin
          check("done_after_halt", done, 1);
          check("busy_in_done", busy, 0);
        end else begin
          check("fetch_after_retire", ir_load, 1);
        end
        post_pending = 1'b0;
      end
      check("rw_mw_exclusive", RegWrite & MemWrite, 0);
      if (ir_load) begin
        cyc = 0;
        check("fetch_aluop", ALUOp, 7);
        check("fetch_busy", busy, 1);
        check("fetch_done", done, 0);
        check("fetch_strobes", {pc_en, Branch, ALUSrc, MemWrite, MemtoReg, RegWrite}, 0);
      end else if (cyc >= 0) begin
        cyc++;
      end
      if (pc_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pc_en", 1, 0);
        end else begin
          mon_r = exp_q.pop_front();
          check("latency", cyc, mon_r.lat);
          check("aluop", ALUOp, mon_r.aluop);
          check("branch", Branch, mon_r.branch);
          check("regwrite", RegWrite, mon_r.rw);
          check("memtoreg", MemtoReg, mon_r.m2r);
          check("memwrite", MemWrite, mon_r.mw);
          check("alusrc", ALUSrc, mon_r.alusrc);
          post_rec = mon_r;
          post_pending = 1'b1;
        end
      end
    end
  end

  // Model: predict the completion cycle (offset from FETCH) and strobes from the opcode rules.
  task automatic run_instr(input int op, input bit zv, input int w, input bit hv);
    rec_t r;
    bit   ill, mem_op, tmo;
    ill    = op > 7;
    mem_op = !ill && (op == 3 || op == 4);
    tmo    = mem_op && (w >= TIMEOUT);
    r.aluop  = (!ill && op <= 2) ? op : 7;
    r.branch = 0; r.rw = 0; r.m2r = 0; r.mw = 0; r.alusrc = 0;
    if (ill) begin
      r.lat = 2;
    end else if (op == 6) begin
      r.lat = 2;
      r.branch = !zv;
    end else if (mem_op) begin
      r.mw = (op == 4);
      if (tmo) begin
        r.lat = 2 + TIMEOUT;
        r.alusrc = 1;
      end else if (op == 3) begin
        r.lat = 4 + w;
        r.rw = 1;
        r.m2r = 1;
      end else begin
        r.lat = 3 + w;
        r.alusrc = 1;
      end
    end else begin
      r.lat = 3;
      r.rw = 1;
      r.alusrc = (op == 7);
    end
    if (ill || tmo) m_err = 1'b1;
    else if (m_retired < 3) m_retired++;
    r.retired = m_retired;
    r.err = m_err;
    r.halt = hv;
    exp_q.push_back(r);

    if (need_start) begin
      start = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
        halt = 1'($urandom_range(0, 1));
      end
      start = 1'b1;
      @(posedge clk); #1;
      check("fetch_after_start", ir_load, 1);
    end else begin
      @(posedge clk); #1;
    end
    instr = 4'(op);
    zero = zv;
    for (int c = 0; c <= r.lat; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start = 1'($urandom_range(0, 1));
      halt = (c == r.lat) ? hv : 1'($urandom_range(0, 1));
      mem_ready = mem_op && (c - 3 == w);
    end
    need_start = hv;
  endtask

  task automatic run_random(input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 17), $urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", {ir_load, pc_en, Branch, ALUSrc, MemWrite, MemtoReg, RegWrite}, 0);
    check("reset_aluop", ALUOp, 7);
    check("reset_retired", retired, 0);
    check("reset_status", {busy, done, err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", {busy, ir_load}, 0);

    run_instr(0, 0, 0, 1);
    run_instr(3, 0, 3, 0);
    run_instr(6, 0, 0, 0);
    run_instr(6, 1, 0, 0);
    run_instr(7, 0, 0, 0);
    run_instr(4, 0, 15, 0);
    run_instr(9, 0, 0, 1);
    run_instr(4, 0, 2, 0);
    run_instr(1, 0, 0, 0);
    run_instr(2, 1, 0, 0);
    run_instr(5, 0, 0, 0);
    run_random(60);
    run_instr(0, 0, 0, 1);

    start = 1'b0;
    @(posedge clk); #1;
    instr = 4'd4; mem_ready = 1'b0; halt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("store_memwrite", MemWrite, 1);
    check("retired_before_reset", retired, m_retired);
    #2 reset = 1'b1;
    #1;
    check("async_memwrite", MemWrite, 0);
    check("async_busy", busy, 0);
    check("async_retired", retired, 0);
    check("async_err", err, 0);
    check("async_aluop", ALUOp, 7);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_retired = 0;
    m_err = 1'b0;
    need_start = 1'b1;

    run_random(25);
    run_instr(1, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
